// File: rtl/mips_exec_unit.sv
// MIPS execute stage: ALU control decode, 32-bit ALU, branch-target adder
// and the registered ALU result / zero flag handed to the next stage.
module mips_exec_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  ALUOp,
  input  logic [5:0]  FuncCode,
  input  logic [4:0]  shamt,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] pc_out,
  input  logic [31:0] shift_out,
  input  logic        alu_out_en,
  output logic [3:0]  ALUCtrl,
  output logic [31:0] result,
  output logic        zero,
  output logic [31:0] add_out,
  output logic [31:0] alu_out_q,
  output logic        zero_q
);

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_XOR  = 4'b0011;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_SLTU = 4'b1000;
  localparam logic [3:0] CTRL_SLL  = 4'b1001;
  localparam logic [3:0] CTRL_SRL  = 4'b1010;
  localparam logic [3:0] CTRL_SRA  = 4'b1011;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;
  localparam logic [3:0] CTRL_SLLV = 4'b1101;
  localparam logic [3:0] CTRL_SRLV = 4'b1110;
  localparam logic [3:0] CTRL_SRAV = 4'b1111;

  // Decode the control-unit operation class (and R-type funct) into an ALU code;
  // unrecognised funct values fall back to ADD.
  always_comb begin
    ALUCtrl = CTRL_ADD;
    case (ALUOp)
      2'b00: ALUCtrl = CTRL_ADD;
      2'b01: ALUCtrl = CTRL_SUB;
      2'b11: ALUCtrl = CTRL_OR;
      default: begin
        case (FuncCode)
          6'b100000, 6'b100001: ALUCtrl = CTRL_ADD;
          6'b100010, 6'b100011: ALUCtrl = CTRL_SUB;
          6'b100100:            ALUCtrl = CTRL_AND;
          6'b100101:            ALUCtrl = CTRL_OR;
          6'b100110:            ALUCtrl = CTRL_XOR;
          6'b100111:            ALUCtrl = CTRL_NOR;
          6'b101010:            ALUCtrl = CTRL_SLT;
          6'b101011:            ALUCtrl = CTRL_SLTU;
          6'b000000:            ALUCtrl = CTRL_SLL;
          6'b000010:            ALUCtrl = CTRL_SRL;
          6'b000011:            ALUCtrl = CTRL_SRA;
          6'b000100:            ALUCtrl = CTRL_SLLV;
          6'b000110:            ALUCtrl = CTRL_SRLV;
          6'b000111:            ALUCtrl = CTRL_SRAV;
          default:              ALUCtrl = CTRL_ADD;
        endcase
      end
    endcase
  end

  // ALU datapath; arithmetic wraps modulo 2^32 and unused codes yield 0.
  always_comb begin
    result = 32'h0;
    case (ALUCtrl)
      CTRL_AND:  result = a & b;
      CTRL_OR:   result = a | b;
      CTRL_ADD:  result = a + b;
      CTRL_XOR:  result = a ^ b;
      CTRL_SUB:  result = a - b;
      CTRL_SLT:  result = {31'h0, ($signed(a) < $signed(b))};
      CTRL_SLTU: result = {31'h0, (a < b)};
      CTRL_SLL:  result = b << shamt;
      CTRL_SRL:  result = b >> shamt;
      CTRL_SRA:  result = 32'($signed(b) >>> shamt);
      CTRL_NOR:  result = ~(a | b);
      CTRL_SLLV: result = b << a[4:0];
      CTRL_SRLV: result = b >> a[4:0];
      CTRL_SRAV: result = 32'($signed(b) >>> a[4:0]);
      default:   result = 32'h0;
    endcase
  end

  // Zero flag and branch-target adder are pure combinational side outputs.
  always_comb begin
    zero    = (result == 32'h0);
    add_out = pc_out + shift_out;
  end

  // Pipeline register for result/zero, loaded only when enabled and cleared
  // asynchronously while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_out_q <= 32'h0;
      zero_q    <= 1'b0;
    end else if (alu_out_en) begin
      alu_out_q <= result;
      zero_q    <= zero;
    end
  end

endmodule

// File: tb/tb_mips_exec_unit.sv
// Directed-vector bench for mips_exec_unit with a queue-based scoreboard.
module tb_mips_exec_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  ALUOp = 2'b00;
  logic [5:0]  FuncCode = 6'h0;
  logic [4:0]  shamt = 5'h0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic [31:0] pc_out = 32'h0;
  logic [31:0] shift_out = 32'h0;
  logic        alu_out_en = 1'b0;
  logic [3:0]  ALUCtrl;
  logic [31:0] result;
  logic        zero;
  logic [31:0] add_out;
  logic [31:0] alu_out_q;
  logic        zero_q;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    int          idx;
    logic        rst;
    logic        en;
    logic [1:0]  op;
    logic [5:0]  fc;
    logic [4:0]  sh;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] pc;
    logic [31:0] so;
    logic [3:0]  e_ctrl;
    logic [31:0] e_res;
    logic        e_zero;
    logic [31:0] e_add;
    logic [31:0] e_q;
    logic        e_zq;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  mips_exec_unit dut (
    .clk       (clk),
    .reset     (reset),
    .ALUOp     (ALUOp),
    .FuncCode  (FuncCode),
    .shamt     (shamt),
    .a         (a),
    .b         (b),
    .pc_out    (pc_out),
    .shift_out (shift_out),
    .alu_out_en(alu_out_en),
    .ALUCtrl   (ALUCtrl),
    .result    (result),
    .zero      (zero),
    .add_out   (add_out),
    .alu_out_q (alu_out_q),
    .zero_q    (zero_q)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic en, input logic [1:0] op,
                              input logic [5:0] fc, input logic [4:0] sh,
                              input logic [31:0] va, input logic [31:0] vb,
                              input logic [31:0] pc, input logic [31:0] so,
                              input logic [3:0] e_ctrl, input logic [31:0] e_res,
                              input logic e_zero, input logic [31:0] e_add,
                              input logic [31:0] e_q, input logic e_zq);
    vec_t v;
    v.idx = vecs.size();
    v.rst = rst; v.en = en; v.op = op; v.fc = fc; v.sh = sh;
    v.va = va; v.vb = vb; v.pc = pc; v.so = so;
    v.e_ctrl = e_ctrl; v.e_res = e_res; v.e_zero = e_zero;
    v.e_add = e_add; v.e_q = e_q; v.e_zq = e_zq;
    return v;
  endfunction

  // Drive one vector just after a rising edge and queue its expected response.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    reset      = v.rst;
    alu_out_en = v.en;
    ALUOp      = v.op;
    FuncCode   = v.fc;
    shamt      = v.sh;
    a          = v.va;
    b          = v.vb;
    pc_out     = v.pc;
    shift_out  = v.so;
    exp_q.push_back(v);
  endtask

  task automatic checkOutput(input int idx, input string what,
                             input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL v%0d.%s actual=%h required=%h", idx, what, act, req);
    end
  endtask

  // Monitor: on each falling edge, compare the DUT against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t e;
      e = exp_q.pop_front();
      checkOutput(e.idx, "ALUCtrl",   {28'h0, ALUCtrl}, {28'h0, e.e_ctrl});
      checkOutput(e.idx, "result",    result,           e.e_res);
      checkOutput(e.idx, "zero",      {31'h0, zero},    {31'h0, e.e_zero});
      checkOutput(e.idx, "add_out",   add_out,          e.e_add);
      checkOutput(e.idx, "alu_out_q", alu_out_q,        e.e_q);
      checkOutput(e.idx, "zero_q",    {31'h0, zero_q},  {31'h0, e.e_zq});
    end
  end

  initial begin
    //                rst   en    op     fc         sh     a             b             pc            so            ctrl   result        z     add_out       q             zq
    // Reset held: combinational path works, registers ignore enable.
    vecs.push_back(mk(1'b0, 1'b1, 2'b11, 6'h00,     5'd0,  32'h000000F0, 32'h0000000F, 32'h00000100, 32'h00000004, 4'h1, 32'h000000FF, 1'b0, 32'h00000104, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b00, 6'h00,     5'd0,  32'h00000001, 32'h00000002, 32'h0,        32'h0,        4'h2, 32'h00000003, 1'b0, 32'h0,        32'h0,        1'b0));
    // Reset released, enable low: SUB via funct and via ALUOp 01.
    vecs.push_back(mk(1'b1, 1'b0, 2'b10, 6'b100010, 5'd0,  32'h00000005, 32'h00000007, 32'h0,        32'h0,        4'h6, 32'hFFFFFFFE, 1'b0, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b01, 6'h00,     5'd0,  32'h00000009, 32'h00000009, 32'h0,        32'h0,        4'h6, 32'h00000000, 1'b1, 32'h0,        32'h0,        1'b0));
    // Signed versus unsigned compare.
    vecs.push_back(mk(1'b1, 1'b0, 2'b10, 6'b101010, 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h0,        4'h7, 32'h00000001, 1'b0, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b10, 6'b101011, 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h0,        4'h8, 32'h00000000, 1'b1, 32'h0,        32'h0,        1'b0));
    // Shifts: SRA by shamt, SRLV by a[4:0].
    vecs.push_back(mk(1'b1, 1'b0, 2'b10, 6'b000011, 5'd4,  32'h0,        32'h80000000, 32'h0,        32'h0,        4'hB, 32'hF8000000, 1'b0, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b10, 6'b000110, 5'd0,  32'h00000023, 32'h000000F0, 32'h0,        32'h0,        4'hE, 32'h0000001E, 1'b0, 32'h0,        32'h0,        1'b0));
    // Branch-target adder, including wrap past 2^32.
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 6'h00,     5'd0,  32'h0,        32'h0,        32'hBFC00000, 32'h00000010, 4'h2, 32'h00000000, 1'b1, 32'hBFC00010, 32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b10, 6'b000000, 5'd8,  32'h0,        32'h000000FF, 32'hFFFFFFFC, 32'h00000008, 4'h9, 32'h0000FF00, 1'b0, 32'h00000004, 32'h0,        1'b0));
    // Logic ops and remaining shifts.
    vecs.push_back(mk(1'b1, 1'b0, 2'b10, 6'b100111, 5'd0,  32'h0F0F0F0F, 32'h00FF00FF, 32'h0,        32'h0,        4'hC, 32'hF000F000, 1'b0, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b10, 6'b100110, 5'd0,  32'hFF00FF00, 32'h0FF00FF0, 32'h0,        32'h0,        4'h3, 32'hF0F0F0F0, 1'b0, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b10, 6'b100100, 5'd0,  32'hFFFF0000, 32'h12345678, 32'h0,        32'h0,        4'h0, 32'h12340000, 1'b0, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b10, 6'b000111, 5'd0,  32'h00000024, 32'h80000010, 32'h0,        32'h0,        4'hF, 32'hF8000001, 1'b0, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b10, 6'b000100, 5'd0,  32'h00000021, 32'h00000003, 32'h0,        32'h0,        4'hD, 32'h00000006, 1'b0, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b10, 6'b000010, 5'd4,  32'h0,        32'h80000000, 32'h0,        32'h0,        4'hA, 32'h08000000, 1'b0, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b10, 6'b111111, 5'd0,  32'h00000002, 32'h00000003, 32'h0,        32'h0,        4'h2, 32'h00000005, 1'b0, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b10, 6'b100001, 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h0,        4'h2, 32'h00000000, 1'b1, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b10, 6'b100101, 5'd0,  32'h000000F0, 32'h0000000F, 32'h0,        32'h0,        4'h1, 32'h000000FF, 1'b0, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b10, 6'b100011, 5'd0,  32'h00000000, 32'h00000001, 32'h0,        32'h0,        4'h6, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h0,        1'b0));
    // Capture, then hold while inputs change.
    vecs.push_back(mk(1'b1, 1'b1, 2'b00, 6'h00,     5'd0,  32'h12340000, 32'h00005678, 32'h0,        32'h0,        4'h2, 32'h12345678, 1'b0, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 6'h00,     5'd0,  32'h00000001, 32'h00000001, 32'h0,        32'h0,        4'h2, 32'h00000002, 1'b0, 32'h0,        32'h12345678, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b01, 6'h00,     5'd0,  32'h00000005, 32'h00000005, 32'h0,        32'h0,        4'h6, 32'h00000000, 1'b1, 32'h0,        32'h12345678, 1'b0));
    // Mid-cycle reset clears alu_out_q immediately; OR still works.
    vecs.push_back(mk(1'b0, 1'b0, 2'b11, 6'h00,     5'd0,  32'h000000F0, 32'h0000000F, 32'h0,        32'h0,        4'h1, 32'h000000FF, 1'b0, 32'h0,        32'h0,        1'b0));
    // Capture a zero result so zero_q is set, then reset again.
    vecs.push_back(mk(1'b1, 1'b1, 2'b01, 6'h00,     5'd0,  32'h00000005, 32'h00000005, 32'h0,        32'h0,        4'h6, 32'h00000000, 1'b1, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 6'h00,     5'd0,  32'h00000007, 32'h00000000, 32'h0,        32'h0,        4'h2, 32'h00000007, 1'b0, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 2'b00, 6'h00,     5'd0,  32'h00000001, 32'h00000001, 32'h0,        32'h0,        4'h2, 32'h00000002, 1'b0, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 6'h00,     5'd0,  32'h00000001, 32'h00000001, 32'h0,        32'h0,        4'h2, 32'h00000002, 1'b0, 32'h0,        32'h0,        1'b0));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(posedge clk);
    if (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
    end
    #2;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mips_exec_unit.md
MIPS_EXEC_UNIT -- requirements
Module: mips_exec_unit

Interface
REQ-001 The block SHALL have these ports: clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have these ports: reset, input, 1 bit; reset is asynchronous and active-low.
REQ-003 The block SHALL have these ports: ALUOp, input, 2 bits, operation class from the control unit.
REQ-004 The block SHALL have these ports: FuncCode, input, 6 bits, instr[5:0].
REQ-005 The block SHALL have these ports: shamt, input, 5 bits, instr[10:6].
REQ-006 The block SHALL have these ports: a, input, 32 bits, ALU operand A (register rs).
REQ-007 The block SHALL have these ports: b, input, 32 bits, ALU operand B (rt or extended immediate).
REQ-008 The block SHALL have these ports: pc_out, input, 32 bits, current PC.
REQ-009 The block SHALL have these ports: shift_out, input, 32 bits, branch offset already shifted left 2.
REQ-010 The block SHALL have these ports: alu_out_en, input, 1 bit, load enable for the registered result.
REQ-011 The block SHALL have these ports: ALUCtrl, output, 4 bits, decoded ALU control code.
REQ-012 The block SHALL have these ports: result, output, 32 bits, combinational ALU result.
REQ-013 The block SHALL have these ports: zero, output, 1 bit, 1 when result == 0.
REQ-014 The block SHALL have these ports: add_out, output, 32 bits, branch target adder output.
REQ-015 The block SHALL have these ports: alu_out_q, output, 32 bits, registered result.
REQ-016 The block SHALL have these ports: zero_q, output, 1 bit, registered zero.

Function
REQ-017 ALUCtrl decode SHALL be combinational: ALUOp 00 -> 0010 ADD; ALUOp 01 -> 0110 SUB; ALUOp 11 -> 0001 OR; ALUOp 10 -> decode from FuncCode.
REQ-018 FuncCode decode SHALL be: 100000/100001 -> 0010 ADD; 100010/100011 -> 0110 SUB; 100100 -> 0000 AND; 100101 -> 0001 OR; 100110 -> 0011 XOR; 100111 -> 1100 NOR.
REQ-019 FuncCode decode SHALL also be: 101010 -> 0111 SLT; 101011 -> 1000 SLTU; 000000 -> 1001 SLL; 000010 -> 1010 SRL; 000011 -> 1011 SRA; 000100 -> 1101 SLLV; 000110 -> 1110 SRLV; 000111 -> 1111 SRAV.
REQ-020 Any other FuncCode with ALUOp 10 SHALL decode to 0010 ADD.
REQ-021 The ALU SHALL be combinational and modulo 2^32: ADD a+b; SUB a-b; AND, OR, XOR, NOR bitwise.
REQ-022 SLT SHALL return 1 if signed a < signed b, else 0; SLTU SHALL do the same with an unsigned compare.
REQ-023 SLL, SRL and SRA SHALL shift b by shamt.
REQ-024 SLLV, SRLV and SRAV SHALL shift b by a[4:0].
REQ-025 SRA and SRAV SHALL replicate b[31].
REQ-026 ALUCtrl codes 0100 and 0101 SHALL produce result 0.
REQ-027 ADD/SUB overflow SHALL be ignored; there SHALL be no exception output.
REQ-028 zero SHALL equal 1 exactly when result == 32'h0, for every operation.
REQ-029 add_out SHALL equal pc_out + shift_out, modulo 2^32, combinational, independent of ALUOp.
REQ-030 On a rising clk edge with alu_out_en = 1, alu_out_q <= result and zero_q <= zero.
REQ-031 With alu_out_en = 0, alu_out_q and zero_q SHALL hold their values.
REQ-032 The combinational outputs (ALUCtrl, result, zero, add_out) SHALL have zero-cycle latency; the registered outputs SHALL have one-cycle latency.

Reset
REQ-033 reset low SHALL immediately, without waiting for clk, force alu_out_q = 0 and zero_q = 0.
REQ-034 While reset is low, the registers SHALL ignore clk and alu_out_en.
REQ-035 The combinational outputs SHALL remain functional during reset.
REQ-036 The first capture after reset rises SHALL occur on the first rising edge with alu_out_en = 1.

Verification
REQ-037 ALUOp=10, FuncCode=100010, a=5, b=7 -> ALUCtrl=0110, result=FFFFFFFE, zero=0; ALUOp=01, a=b=9 -> result=0, zero=1.
REQ-038 ALUOp=10, FuncCode=101010, a=FFFFFFFF, b=1 -> result=1; same with FuncCode=101011 -> result=0.
REQ-039 ALUOp=10, FuncCode=000011, shamt=4, b=80000000 -> result=F8000000; FuncCode=000110, a=23, b=F0 -> result=1E (shift by 3).
REQ-040 pc_out=BFC00000, shift_out=00000010 -> add_out=BFC00010; pc_out=FFFFFFFC, shift_out=8 -> add_out=00000004.
REQ-041 alu_out_en=1 with result=12345678 and a rising edge -> alu_out_q=12345678; then alu_out_en=0 and the inputs change -> alu_out_q holds.
REQ-042 reset driven low mid-cycle -> alu_out_q=0 and zero_q=0 before the next edge; ALUOp=11, a=F0, b=0F during reset -> result=FF.
